// File: rtl/icarus_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings,
// pipeline-register layouts with their bubble values, and lane helpers.
package icarus_mem_pkg;

   localparam int DMEM_DEPTH_DEFAULT = 1024;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_RSVD = 2'b11
   } mem_size_e;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] store_data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      mem_size_e   size;
      logic        mem_signed;
      logic        mem_to_reg;
   } exmem_t;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        reg_write;
      logic        align_fault;
   } memwb_t;

   localparam exmem_t EXMEM_BUBBLE = '0;
   localparam memwb_t MEMWB_BUBBLE = '0;

   // Byte lanes touched by an access; half ignores a[0], word ignores a[1:0].
   function automatic logic [3:0] lane_mask(input mem_size_e size, input logic [1:0] a);
      logic [3:0] m;
      case (size)
         SIZE_BYTE: m = 4'b0001 << a;
         SIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         default:   m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] d);
      logic [31:0] r;
      case (size)
         SIZE_BYTE: r = {4{d[7:0]}};
         SIZE_HALF: r = {2{d[15:0]}};
         default:   r = d;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] a,
                                                input mem_size_e size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[8*a +: 8];
      h = a[1] ? word[31:16] : word[15:0];
      case (size)
         SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
         SIZE_HALF: r = {{16{sgn & h[15]}}, h};
         default:   r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/DataMemory.sv
// Word-organised data memory with per-byte-lane write enables and an
// asynchronous read port; contents are never reset.
module DataMemory #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_index,
   input  logic [3:0]    i_byte_we,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      for (int l = 0; l < 4; l++) begin
         if (i_byte_we[l]) r_mem[i_index][8*l +: 8] <= i_wdata[8*l +: 8];
      end
   end

   assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory access, MEM/WB register.
// Optional alignment checking is enabled by defining MEM_ALIGN_CHECK_EN.
module mem_stage
   import icarus_mem_pkg::*;
#(
   parameter int DMEM_DEPTH = DMEM_DEPTH_DEFAULT,
   parameter int ADDR_LSB   = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] EX_ALUResult,
   input  logic [31:0] EX_StoreData,
   input  logic [4:0]  EX_RegDest,
   input  logic        EX_RegWrite,
   input  logic        EX_MemRead,
   input  logic        EX_MemWrite,
   input  logic [1:0]  EX_MemSize,
   input  logic        EX_MemSigned,
   input  logic        EX_MemToReg,
   input  logic        Stall,
   input  logic        Flush,
   output logic [4:0]  EXMEM_RegDest,
   output logic        EXMEM_WriteEnable,
   output logic [31:0] FWFromMEM,
   output logic [4:0]  MEMWB_RegDest,
   output logic        MEMWB_WriteEnable,
   output logic [31:0] FWFromWB,
   output logic        AlignFault
);

   localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   exmem_t      w_exmem_in;
   exmem_t      r_exmem;
   memwb_t      w_memwb_next;
   memwb_t      r_memwb;
   logic [9:0]  w_word_idx;
   logic [AW-1:0] w_index;
   logic [1:0]  w_lane;
   logic        w_misaligned;
   logic        w_store;
   logic [3:0]  w_byte_we;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;
   logic [31:0] w_load;

   always_comb begin
      w_exmem_in            = EXMEM_BUBBLE;
      w_exmem_in.alu        = EX_ALUResult;
      w_exmem_in.store_data = EX_StoreData;
      w_exmem_in.rd         = EX_RegDest;
      w_exmem_in.reg_write  = EX_RegWrite;
      w_exmem_in.mem_read   = EX_MemRead;
      w_exmem_in.mem_write  = EX_MemWrite;
      w_exmem_in.size       = mem_size_e'(EX_MemSize);
      w_exmem_in.mem_signed = EX_MemSigned;
      w_exmem_in.mem_to_reg = EX_MemToReg;
   end

   // Stall/Flush contract: Reset beats Flush beats Stall. A stall freezes
   // EX/MEM and pushes a bubble into MEM/WB; a flush bubbles EX/MEM only.
   always_ff @(posedge Clock) begin
      if (!Reset)      r_exmem <= EXMEM_BUBBLE;
      else if (Flush)  r_exmem <= EXMEM_BUBBLE;
      else if (!Stall) r_exmem <= w_exmem_in;
   end

   assign w_word_idx = r_exmem.alu[ADDR_LSB+9:ADDR_LSB];
   assign w_index    = AW'(32'(w_word_idx) % 32'(DMEM_DEPTH));
   assign w_lane     = r_exmem.alu[1:0];

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misaligned = (r_exmem.mem_read | r_exmem.mem_write) &
                         (((r_exmem.size == SIZE_HALF) & w_lane[0]) |
                          ((r_exmem.size != SIZE_BYTE) & (r_exmem.size != SIZE_HALF) & (|w_lane)));
`else
   assign w_misaligned = 1'b0;
`endif

   // Write only on the edge that advances the store out of EX/MEM, so a
   // held store is written exactly once.
   assign w_store   = r_exmem.mem_write & ~Stall & Reset & ~w_misaligned;
   assign w_byte_we = w_store ? lane_mask(r_exmem.size, w_lane) : 4'b0000;
   assign w_wdata   = store_lanes(r_exmem.size, r_exmem.store_data);

   DataMemory #(
      .DEPTH (DMEM_DEPTH),
      .AW    (AW)
   ) u_dmem (
      .i_clk     (Clock),
      .i_index   (w_index),
      .i_byte_we (w_byte_we),
      .i_wdata   (w_wdata),
      .o_rdata   (w_rdata)
   );

   // A non-load that asks for load data gets zero rather than stale memory.
   assign w_load = r_exmem.mem_read
                   ? load_extract(w_rdata, w_lane, r_exmem.size, r_exmem.mem_signed)
                   : 32'h0;

   always_comb begin
      w_memwb_next             = MEMWB_BUBBLE;
      w_memwb_next.data        = r_exmem.mem_to_reg ? w_load : r_exmem.alu;
      w_memwb_next.rd          = r_exmem.rd;
      w_memwb_next.reg_write   = r_exmem.reg_write & ~w_misaligned;
      w_memwb_next.align_fault = w_misaligned;
   end

   always_ff @(posedge Clock) begin
      if (!Reset)     r_memwb <= MEMWB_BUBBLE;
      else if (Stall) r_memwb <= MEMWB_BUBBLE;
      else            r_memwb <= w_memwb_next;
   end

   assign EXMEM_RegDest     = r_exmem.rd;
   assign EXMEM_WriteEnable = r_exmem.reg_write & (|r_exmem.rd);
   assign FWFromMEM         = r_exmem.alu;
   assign MEMWB_RegDest     = r_memwb.rd;
   assign MEMWB_WriteEnable = r_memwb.reg_write & (|r_memwb.rd);
   assign FWFromWB          = r_memwb.data;
   assign AlignFault        = r_memwb.align_fault;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have these parameters: DMEM_DEPTH, default 1024, data-memory depth in 32-bit words; ADDR_LSB, default 2, lowest address bit of the word index.
REQ-002 SHALL have these ports, listed as name, direction, width, meaning:
  - Clock, in, 1: rising-edge clock.
  - Reset, in, 1: one clock; reset is synchronous and active-low.
  - EX_ALUResult, in, 32: memory address or ALU result.
  - EX_StoreData, in, 32: store data, already forwarded.
  - EX_RegDest, in, 5: destination register.
  - EX_RegWrite, in, 1: instruction writes the register file.
  - EX_MemRead, in, 1: load.
  - EX_MemWrite, in, 1: store.
  - EX_MemSize, in, 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
  - EX_MemSigned, in, 1: sign-extend loads.
  - EX_MemToReg, in, 1: write-back selects load data.
  - Stall, in, 1: hold the EX/MEM register.
  - Flush, in, 1: load a bubble into the EX/MEM register.
  - EXMEM_RegDest, out, 5: destination register held in EX/MEM.
  - EXMEM_WriteEnable, out, 1: EX/MEM register-write qualifier.
  - FWFromMEM, out, 32: EX/MEM ALU result, used for forwarding.
  - MEMWB_RegDest, out, 5: destination register held in MEM/WB.
  - MEMWB_WriteEnable, out, 1: MEM/WB register-write qualifier.
  - FWFromWB, out, 32: write-back data.
  - AlignFault, out, 1: registered misalignment flag.

Function
REQ-003 SHALL capture EX_* into the EX/MEM register on every edge where Reset=1, Stall=0 and Flush=0.
REQ-004 SHALL load a bubble into EX/MEM on Flush=1 (bubble: RegWrite=0, MemRead=0, MemWrite=0, RegDest=0, data=0), and Flush SHALL take priority over Stall.
REQ-005 SHALL hold EX/MEM unchanged on Stall=1 with Flush=0, and SHALL load a bubble into MEM/WB on that same edge.
REQ-006 SHALL drive EXMEM_WriteEnable = EX/MEM RegWrite AND (EXMEM_RegDest != 0), and MEMWB_WriteEnable likewise from MEM/WB.
REQ-007 SHALL drive FWFromMEM = EX/MEM ALU result.
REQ-008 SHALL NOT forward load data from EX/MEM; load-use hazards belong to the upstream hazard unit.
REQ-009 SHALL perform a store at the edge ending the cycle in which EX/MEM MemWrite=1 and Stall=0, so that each store is written exactly once.
REQ-010 SHALL index the data memory by address[ADDR_LSB+9:ADDR_LSB]; upper address bits are ignored and the index wraps modulo DMEM_DEPTH.
REQ-011 SHALL store little-endian: a byte store writes lane addr[1:0] from StoreData[7:0]; a half store writes lanes {addr[1],0} and {addr[1],1} from StoreData[15:0]; a word store writes all lanes; unwritten lanes are unchanged.
REQ-012 SHALL read the memory combinationally in the MEM cycle, extract the addressed byte or half, and zero- or sign-extend it per MemSigned.
REQ-013 SHALL register into MEM/WB, at the next edge, either the extracted load data or the ALU result, selected by MemToReg.
REQ-014 SHALL have a latency of 1 edge from EX inputs to EXMEM_* and 2 edges to MEMWB_*/FWFromWB.
REQ-015 SHALL return the new data to a load issued the cycle immediately after a store to the same word (write-before-read ordering across cycles).
REQ-016 SHALL NOT perform a memory write for a bubble or for a flushed instruction.

Reset
REQ-017 SHALL, on an edge with Reset=0, clear all EX/MEM and MEM/WB fields and AlignFault to 0, overriding Stall and Flush.
REQ-018 SHALL NOT initialise memory contents on reset, and SHALL suppress any store pending in EX/MEM on a reset edge.

Configuration
REQ-019 SHALL, with MEM_ALIGN_CHECK_EN defined, treat a half access with addr[0]=1 or a word access with addr[1:0]!=0 as misaligned.
REQ-020 SHALL, for a misaligned access with MEM_ALIGN_CHECK_EN defined, suppress the store, clear RegWrite in MEM/WB, and set AlignFault=1 for exactly the one MEM/WB cycle of that instruction.
REQ-021 SHALL, without MEM_ALIGN_CHECK_EN, force alignment (half ignores addr[0], word ignores addr[1:0]) and tie AlignFault to 0, keeping the port present.

Structure
REQ-022 SHALL take from shared package icarus_mem_pkg: the MemSize encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD), DMEM_DEPTH_DEFAULT, and the bubble constant.
REQ-023 SHALL place the storage in one sub-module, DataMemory, providing a per-byte-lane write enable and an asynchronous read.

Verification
REQ-024 SHALL cover: store word 0xDEADBEEF at address 0x40, then load word from 0x40 on the next cycle -> FWFromWB=0xDEADBEEF, two edges after the load enters.
REQ-025 SHALL cover: store byte 0x80 at address 0x41, then signed load byte from 0x41 -> 0xFFFFFF80; unsigned load -> 0x00000080; word at 0x40 -> 0xDEAD80EF.
REQ-026 SHALL cover: hold Stall=1 for 3 cycles with a store in EX/MEM -> exactly one memory write, MEMWB_WriteEnable=0 for 3 cycles, and EXMEM_* constant.
REQ-027 SHALL cover: Stall=1 and Flush=1 together with a store in EX -> EX/MEM becomes a bubble and memory is unchanged.
REQ-028 SHALL cover: RegWrite=1 with RegDest=0, ALUResult=5 -> EXMEM_WriteEnable=0 and MEMWB_WriteEnable=0.
REQ-029 SHALL cover, with MEM_ALIGN_CHECK_EN: load word from 0x42 -> AlignFault=1 for one cycle and MEMWB_WriteEnable=0; Reset=0 mid-stream -> all outputs 0 on the next edge.
